// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for seq_multiplier: sequencing, iteration counter, ready/done.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_ready,
  output logic o_done,
  output logic o_load,
  output logic o_iter,
  output logic o_last
);

  localparam int CW = cnt_width(WIDTH);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_done;

  assign o_ready = r_ready;
  assign o_done  = r_done;
  assign o_load  = i_start & r_ready;
  assign o_iter  = (r_state == RUN);
  assign o_last  = o_iter & (r_cnt == CW'(1));

  // NOTE: all state and registered outputs update with <= so every branch
  // sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_cnt   <= CW'(WIDTH);
            r_ready <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, unsigned or two's-complement per operation.
// Datapath here; sequencing lives in seq_mult_ctrl.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  logic               w_load;
  logic               w_iter;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;

  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mul;
  logic [WIDTH:0]     r_acc;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_p;

  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .i_start (start),
    .o_ready (ready),
    .o_done  (done),
    .o_load  (w_load),
    .o_iter  (w_iter),
    .o_last  (w_last)
  );

  // Negating the most-negative value wraps to 2^(WIDTH-1), which is exactly
  // the magnitude when read as unsigned.
  assign w_a_mag = (signed_mode & a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (signed_mode & b[WIDTH-1]) ? -b : b;

  assign w_addend = r_mul[0] ? {1'b0, r_mag_a} : '0;
  assign w_sum    = r_acc + w_addend;
  // Product as it stands after this edge's add-and-shift.
  assign w_prod   = {w_sum, r_mul[WIDTH-1:1]};

  assign p = r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag_a <= '0;
      r_mul   <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_p     <= '0;
    end else if (w_load) begin
      r_mag_a <= w_a_mag;
      r_mul   <= w_b_mag;
      r_acc   <= '0;
      r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (w_iter) begin
      r_acc <= {1'b0, w_sum[WIDTH:1]};
      r_mul <= {w_sum[0], r_mul[WIDTH-1:1]};
      if (w_last) begin
        r_p <= r_neg ? -w_prod : w_prod;
      end
    end
  end

endmodule
